set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: CPU word-address width.
REQ-002 Parameter WORD_WIDTH, default 32: data word width, multiple of 8.
REQ-003 Parameter LINE_WORDS, default 4: words per line, power of 2, >=2.
REQ-004 Parameter SETS, default 32: number of sets, power of 2; ways fixed at 2.
REQ-005 Derived: OFF=log2(LINE_WORDS), IDX=log2(SETS), TAG=ADDR_WIDTH-OFF-IDX, LINE=WORD_WIDTH*LINE_WORDS.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cpu_req  in  1  access request, held with addr/we/be/wdata until cpu_ready.
REQ-009 cpu_we  in  1  1 = write, 0 = read.
REQ-010 cpu_addr  in  ADDR_WIDTH  word address {tag, index, offset}.
REQ-011 cpu_be  in  WORD_WIDTH/8  byte enables for writes.
REQ-012 cpu_wdata  in  WORD_WIDTH  write data.
REQ-013 cpu_rdata  out  WORD_WIDTH  read data, valid when cpu_ready=1.
REQ-014 cpu_ready  out  1  access completes this cycle.
REQ-015 mem_req  out  1  memory line transfer request, held until mem_ack.
REQ-016 mem_we  out  1  1 = writeback, 0 = refill.
REQ-017 mem_addr  out  ADDR_WIDTH-OFF  line address {tag, index}.
REQ-018 mem_wline  out  LINE  writeback line data.
REQ-019 mem_ack  in  1  single-cycle transfer completion.
REQ-020 mem_rline  in  LINE  refill data, valid with mem_ack during refill.

Function
REQ-021 Per set, per way: data line, TAG-bit tag, valid bit, dirty bit; per set: one LRU bit naming the least-recently-used way.
REQ-022 FSM states IDLE, WRITEBACK, REFILL; lookup is combinational in IDLE.
REQ-023 IDLE, cpu_req=1, hit in way w: cpu_ready=1 same cycle; read returns word[offset] of way w; write commits at clock edge.
REQ-024 Write hit: only bytes with cpu_be=1 updated; dirty[w] set; be=0 completes with no data change but still sets dirty.
REQ-025 Every hit sets LRU[index] to the other way (1-w).
REQ-026 Miss victim: way 0 if invalid, else way 1 if invalid, else way LRU[index].
REQ-027 Miss with victim valid and dirty: go to WRITEBACK; else go to REFILL; cpu_ready=0 on miss.
REQ-028 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wline=victim line; on mem_ack go to REFILL.
REQ-029 REFILL: mem_req=1, mem_we=0, mem_addr={cpu tag, index}; on mem_ack write mem_rline to victim, set valid, tag, clear dirty, return to IDLE.
REQ-030 After refill the held request hits in IDLE the next cycle (miss latency = ack cycles + 1), and LRU updates per REQ-025.
REQ-031 Victim way latched at miss detection, stable through WRITEBACK/REFILL.
REQ-032 mem_ack ignored in IDLE; cpu_req deasserted mid-miss does not abort the transfer.
REQ-033 cpu_ready is never 1 outside IDLE; mem_req is never 1 in IDLE.
REQ-034 Index, offset and tag slicing follow REQ-005 for every legal parameter set.

Reset
REQ-035 reset=1 immediately forces IDLE, clears all valid, dirty and LRU bits; cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wline=0, cpu_rdata=0.
REQ-036 Data and tag arrays are not reset; reset mid-transfer abandons it with no array update.

Verification (defaults)
REQ-037 After reset, read 0x040 -> miss, mem_req=1, mem_we=0, mem_addr=0x010; ack with line {D,C,B,A} -> next cycle cpu_ready=1, cpu_rdata=0xA.
REQ-038 Word holds 0xAABBCCDD; write be=4'b0011, wdata=0xFFFF1234 -> ready same cycle; read back 0xAABB1234.
REQ-039 Fill set 0 with tags 1 then 2, read tag 1, read tag 3 -> tag 2 (way 1) evicted; tag 1 still hits.
REQ-040 Dirty victim: write tag 1 line, force eviction -> WRITEBACK with mem_we=1, mem_addr={1, index}, mem_wline=modified line, then REFILL.
REQ-041 reset=1 during REFILL -> mem_req=0 immediately; re-reading 0x040 misses again.
REQ-042 Hold mem_ack=0 for 10 cycles in REFILL -> mem_req, mem_addr stable, cpu_ready=0 throughout.

Source files
------------

// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-back cache with per-set LRU, a combinational
// lookup in IDLE and a single-ported line interface to memory for writeback/refill.
module set_assoc_cache #(
   parameter int ADDR_WIDTH = 12,
   parameter int WORD_WIDTH = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 32
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              cpu_req,
   input  logic                                              cpu_we,
   input  logic [ADDR_WIDTH-1:0]                             cpu_addr,
   input  logic [WORD_WIDTH/8-1:0]                           cpu_be,
   input  logic [WORD_WIDTH-1:0]                             cpu_wdata,
   output logic [WORD_WIDTH-1:0]                             cpu_rdata,
   output logic                                              cpu_ready,
   output logic                                              mem_req,
   output logic                                              mem_we,
   output logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0]          mem_addr,
   output logic [WORD_WIDTH*LINE_WORDS-1:0]                  mem_wline,
   input  logic                                              mem_ack,
   input  logic [WORD_WIDTH*LINE_WORDS-1:0]                  mem_rline
);

   localparam int OFF   = $clog2(LINE_WORDS);
   localparam int IDX   = $clog2(SETS);
   localparam int TAG   = ADDR_WIDTH - OFF - IDX;
   localparam int LINE  = WORD_WIDTH * LINE_WORDS;
   localparam int BYTES = WORD_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_s;

   logic [LINE-1:0]       data_r [0:1][0:SETS-1];
   logic [TAG-1:0]        tag_r  [0:1][0:SETS-1];
   logic [1:0][SETS-1:0]  valid_r;
   logic [1:0][SETS-1:0]  dirty_r;
   logic [SETS-1:0]       lru_r;

   logic                  victim_r;
   logic [TAG-1:0]        miss_tag_r;
   logic [IDX-1:0]        miss_idx_r;

   logic [TAG-1:0]        tag_s;
   logic [IDX-1:0]        idx_s;
   logic [OFF-1:0]        off_s;
   logic                  hit0_s;
   logic                  hit1_s;
   logic                  hit_s;
   logic                  hit_way_s;
   logic                  victim_s;
   logic [LINE-1:0]       hit_line_s;
   logic [WORD_WIDTH-1:0] hit_words_s [0:LINE_WORDS-1];
   logic [LINE-1:0]       write_line_s;

   function automatic logic [WORD_WIDTH-1:0] merge_word(
      input logic [WORD_WIDTH-1:0] old_word,
      input logic [WORD_WIDTH-1:0] new_word,
      input logic [BYTES-1:0]      be
   );
      logic [WORD_WIDTH-1:0] res;
      res = old_word;
      for (int b = 0; b < BYTES; b++) begin
         if (be[b]) begin
            res[b*8 +: 8] = new_word[b*8 +: 8];
         end else begin
            res[b*8 +: 8] = old_word[b*8 +: 8];
         end
      end
      return res;
   endfunction

   assign tag_s = cpu_addr[ADDR_WIDTH-1 -: TAG];
   assign idx_s = cpu_addr[OFF +: IDX];
   assign off_s = cpu_addr[OFF-1:0];

   // Tag compare, hit way and victim choice for the presented address.
   always_comb begin
      hit0_s     = valid_r[0][idx_s] && (tag_r[0][idx_s] == tag_s);
      hit1_s     = valid_r[1][idx_s] && (tag_r[1][idx_s] == tag_s);
      hit_s      = hit0_s || hit1_s;
      hit_way_s  = hit1_s;
      hit_line_s = hit1_s ? data_r[1][idx_s] : data_r[0][idx_s];
      if (!valid_r[0][idx_s]) begin
         victim_s = 1'b0;
      end else if (!valid_r[1][idx_s]) begin
         victim_s = 1'b1;
      end else begin
         victim_s = lru_r[idx_s];
      end
   end

   // Split the hit line into words and build the byte-merged line for a write hit.
   always_comb begin
      write_line_s = hit_line_s;
      for (int k = 0; k < LINE_WORDS; k++) begin
         hit_words_s[k] = hit_line_s[k*WORD_WIDTH +: WORD_WIDTH];
         if (OFF'(k) == off_s) begin
            write_line_s[k*WORD_WIDTH +: WORD_WIDTH] =
               merge_word(hit_line_s[k*WORD_WIDTH +: WORD_WIDTH], cpu_wdata, cpu_be);
         end else begin
            write_line_s[k*WORD_WIDTH +: WORD_WIDTH] = hit_line_s[k*WORD_WIDTH +: WORD_WIDTH];
         end
      end
   end

   // Next-state decode and CPU/memory handshake outputs.
   always_comb begin
      state_s   = state_r;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wline = '0;
      case (state_r)
         IDLE: begin
            if (cpu_req) begin
               if (hit_s) begin
                  cpu_ready = 1'b1;
                  cpu_rdata = hit_words_s[off_s];
               end else if (valid_r[victim_s][idx_s] && dirty_r[victim_s][idx_s]) begin
                  state_s = WRITEBACK;
               end else begin
                  state_s = REFILL;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_r[victim_r][miss_idx_r], miss_idx_r};
            mem_wline = data_r[victim_r][miss_idx_r];
            if (mem_ack) begin
               state_s = REFILL;
            end else begin
               state_s = WRITEBACK;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {miss_tag_r, miss_idx_r};
            if (mem_ack) begin
               state_s = IDLE;
            end else begin
               state_s = REFILL;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, status bits and the miss context latched when a miss is detected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         valid_r    <= '0;
         dirty_r    <= '0;
         lru_r      <= '0;
         victim_r   <= 1'b0;
         miss_tag_r <= '0;
         miss_idx_r <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (cpu_req && hit_s) begin
                  lru_r[idx_s] <= ~hit_way_s;
                  if (cpu_we) begin
                     dirty_r[hit_way_s][idx_s] <= 1'b1;
                  end
               end else if (cpu_req) begin
                  victim_r   <= victim_s;
                  miss_tag_r <= tag_s;
                  miss_idx_r <= idx_s;
               end
            end
            REFILL: begin
               if (mem_ack) begin
                  valid_r[victim_r][miss_idx_r] <= 1'b1;
                  dirty_r[victim_r][miss_idx_r] <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Data and tag arrays carry no reset; reset forces IDLE so no write can slip through.
   always_ff @(posedge clk) begin
      if ((state_r == IDLE) && cpu_req && hit_s && cpu_we) begin
         data_r[hit_way_s][idx_s] <= write_line_s;
      end else if ((state_r == REFILL) && mem_ack) begin
         data_r[victim_r][miss_idx_r] <= mem_rline;
         tag_r[victim_r][miss_idx_r]  <= miss_tag_r;
      end
   end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache at default parameters
// (OFF=2, IDX=5, TAG=5); backing memory word k of line L reads {L, k}.
module tb_set_assoc_cache;

   logic         clk;
   logic         reset;
   logic         cpu_req;
   logic         cpu_we;
   logic [11:0]  cpu_addr;
   logic [3:0]   cpu_be;
   logic [31:0]  cpu_wdata;
   logic [31:0]  cpu_rdata;
   logic         cpu_ready;
   logic         mem_req;
   logic         mem_we;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wline;
   logic         mem_ack;
   logic [127:0] mem_rline;

   int errors = 0;
   int checks = 0;
   logic [127:0] tbmem [0:1023];

   set_assoc_cache dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
      .mem_ack(mem_ack), .mem_rline(mem_rline)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] pattern_line(input logic [9:0] l);
      return {6'd0, l, 16'd3, 6'd0, l, 16'd2, 6'd0, l, 16'd1, 6'd0, l, 16'd0};
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Full access with a backing-memory responder; cyc = cycles before ready, -1 on timeout.
   task automatic access(input logic we, input logic [11:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output int cyc, output int wbs);
      rd = 32'd0; cyc = -1; wbs = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (cpu_ready) begin
            rd = cpu_rdata; cyc = i;
            break;
         end else if (mem_req) begin
            if (mem_we) begin
               tbmem[mem_addr] = mem_wline;
               wbs++;
            end
            mem_ack = 1'b1; mem_rline = tbmem[mem_addr];
            tick;
            mem_ack = 1'b0;
         end else begin
            tick;
         end
      end
      tick;
      cpu_req = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
      tick; tick; #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h want 0", cpu_ready); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
      checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
      checks++; if (mem_wline !== 128'h0) begin errors++; $display("FAIL reset_mem_wline: got %0h want 0", mem_wline); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", cpu_rdata); end
      cpu_req = 1'b0; reset = 1'b0;
      tick;
   endtask

   task automatic test_read_miss;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040; #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL miss_ready: got %0h want 0", cpu_ready); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_idle_mem_req: got %0h want 0", mem_req); end
      tick; #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL refill_req: got %0h want 1", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL refill_we: got %0h want 0", mem_we); end
      checks++; if (mem_addr !== 10'h010) begin errors++; $display("FAIL refill_addr: got %0h want 010", mem_addr); end
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL refill_ready: got %0h want 0", cpu_ready); end
      mem_ack = 1'b1; mem_rline = {32'hD, 32'hC, 32'hB, 32'hA};
      tick; mem_ack = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL after_refill_ready: got %0h want 1", cpu_ready); end
      checks++; if (cpu_rdata !== 32'hA) begin errors++; $display("FAIL after_refill_rdata: got %0h want a", cpu_rdata); end
      tick; cpu_addr = 12'h041; #1;
      checks++; if (cpu_rdata !== 32'hB || cpu_ready !== 1'b1) begin errors++; $display("FAIL offset1_rdata: got %0h/%0h want b/1", cpu_rdata, cpu_ready); end
      tick; cpu_req = 1'b0;
      mem_ack = 1'b1; mem_rline = '1; #1;
      checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL idle_ack: got %0h/%0h want 0/0", mem_req, cpu_ready); end
      tick; mem_ack = 1'b0;
      cpu_req = 1'b1; cpu_addr = 12'h040; #1;
      checks++; if (cpu_rdata !== 32'hA || cpu_ready !== 1'b1) begin errors++; $display("FAIL idle_ack_nochange: got %0h/%0h want a/1", cpu_rdata, cpu_ready); end
      tick; cpu_req = 1'b0;
   endtask

   task automatic test_write_hit;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h042; cpu_be = 4'hF; cpu_wdata = 32'hAABBCCDD; #1;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_full_ready: got %0h want 1", cpu_ready); end
      tick; cpu_be = 4'b0011; cpu_wdata = 32'hFFFF1234; #1;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_partial_ready: got %0h want 1", cpu_ready); end
      tick; cpu_be = 4'b0000; cpu_wdata = 32'h0; #1;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL wr_be0_ready: got %0h want 1", cpu_ready); end
      tick; cpu_we = 1'b0; #1;
      checks++; if (cpu_rdata !== 32'hAABB1234) begin errors++; $display("FAIL wr_merge: got %0h want aabb1234", cpu_rdata); end
      tick; cpu_addr = 12'h043; #1;
      checks++; if (cpu_rdata !== 32'hD) begin errors++; $display("FAIL wr_neighbour: got %0h want d", cpu_rdata); end
      tick; cpu_req = 1'b0;
   endtask

   task automatic test_lru_evict;
      logic [31:0] rd;
      int cyc, wbs;
      access(1'b0, 12'h080, 4'h0, 32'h0, rd, cyc, wbs);
      checks++; if (cyc !== 2 || rd !== 32'h00200000) begin errors++; $display("FAIL fill_tag1: got %0d/%0h want 2/00200000", cyc, rd); end
      access(1'b0, 12'h100, 4'h0, 32'h0, rd, cyc, wbs);
      checks++; if (cyc !== 2 || rd !== 32'h00400000) begin errors++; $display("FAIL fill_tag2: got %0d/%0h want 2/00400000", cyc, rd); end
      access(1'b0, 12'h080, 4'h0, 32'h0, rd, cyc, wbs);
      checks++; if (cyc !== 0 || rd !== 32'h00200000) begin errors++; $display("FAIL hit_tag1: got %0d/%0h want 0/00200000", cyc, rd); end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h180; #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL tag3_miss: got %0h want 0", cpu_ready); end
      tick; #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h060) begin errors++; $display("FAIL tag3_refill: got %0h/%0h/%0h want 1/0/060", mem_req, mem_we, mem_addr); end
      mem_ack = 1'b1; mem_rline = tbmem[10'h060];
      tick; mem_ack = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00600000) begin errors++; $display("FAIL tag3_data: got %0h/%0h want 1/00600000", cpu_ready, cpu_rdata); end
      tick; cpu_req = 1'b0;
      access(1'b0, 12'h080, 4'h0, 32'h0, rd, cyc, wbs);
      checks++; if (cyc !== 0 || rd !== 32'h00200000) begin errors++; $display("FAIL tag1_kept: got %0d/%0h want 0/00200000", cyc, rd); end
   endtask

   task automatic test_dirty_writeback;
      logic [31:0] rd;
      int cyc, wbs;
      access(1'b1, 12'h080, 4'hF, 32'h12345678, rd, cyc, wbs);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL dirty_write: got %0d want 0", cyc); end
      access(1'b0, 12'h100, 4'h0, 32'h0, rd, cyc, wbs);
      checks++; if (cyc !== 2 || wbs !== 0) begin errors++; $display("FAIL clean_evict: got %0d/%0d want 2/0", cyc, wbs); end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200; #1;
      tick; #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h020) begin errors++; $display("FAIL wb_req: got %0h/%0h/%0h want 1/1/020", mem_req, mem_we, mem_addr); end
      checks++; if (mem_wline !== {32'h00200003, 32'h00200002, 32'h00200001, 32'h12345678}) begin errors++; $display("FAIL wb_line: got %0h want 00200003002000020020000112345678", mem_wline); end
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL wb_ready: got %0h want 0", cpu_ready); end
      mem_ack = 1'b1; tick; mem_ack = 1'b0; #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h080) begin errors++; $display("FAIL wb_then_refill: got %0h/%0h/%0h want 1/0/080", mem_req, mem_we, mem_addr); end
      mem_ack = 1'b1; mem_rline = tbmem[10'h080];
      tick; mem_ack = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00800000) begin errors++; $display("FAIL wb_final: got %0h/%0h want 1/00800000", cpu_ready, cpu_rdata); end
      tick; cpu_req = 1'b0;
   endtask

   task automatic test_reset_refill;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0C0; #1;
      tick; #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %0h want 1", mem_req); end
      reset = 1'b1; #1;
      checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_async: got %0h/%0h want 0/0", mem_req, cpu_ready); end
      tick; reset = 1'b0; cpu_addr = 12'h040; #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rst_remiss: got %0h want 0", cpu_ready); end
      tick; #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h010) begin errors++; $display("FAIL rst_refill: got %0h/%0h want 1/010", mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rline = tbmem[10'h010];
      tick; mem_ack = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00100000) begin errors++; $display("FAIL rst_data: got %0h/%0h want 1/00100000", cpu_ready, cpu_rdata); end
      tick; cpu_req = 1'b0;
   endtask

   task automatic test_ack_stall;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0C4; #1;
      tick;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h031 || cpu_ready !== 1'b0) begin
            errors++; $display("FAIL stall_cycle%0d: got %0h/%0h/%0h/%0h want 1/0/031/0", i, mem_req, mem_we, mem_addr, cpu_ready);
         end
         if (i == 5) cpu_req = 1'b0;
         tick;
      end
      mem_ack = 1'b1; mem_rline = tbmem[10'h031];
      tick; mem_ack = 1'b0; #1;
      checks++; if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL stall_done: got %0h/%0h want 0/0", mem_req, cpu_ready); end
      cpu_req = 1'b1; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00310000) begin errors++; $display("FAIL stall_hit: got %0h/%0h want 1/00310000", cpu_ready, cpu_rdata); end
      tick; cpu_req = 1'b0;
   endtask

   task automatic test_back_to_back;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0C5; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00310001) begin errors++; $display("FAIL b2b_rd1: got %0h/%0h want 1/00310001", cpu_ready, cpu_rdata); end
      tick; cpu_we = 1'b1; cpu_addr = 12'h0C6; cpu_be = 4'hF; cpu_wdata = 32'h5A5A5A5A; #1;
      checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr: got %0h want 1", cpu_ready); end
      tick; cpu_we = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_rd2: got %0h/%0h want 1/5a5a5a5a", cpu_ready, cpu_rdata); end
      tick; cpu_addr = 12'h0C4; #1;
      checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h00310000) begin errors++; $display("FAIL b2b_rd3: got %0h/%0h want 1/00310000", cpu_ready, cpu_rdata); end
      tick; cpu_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0;
      cpu_be = 4'h0; cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rline = '0;
      for (int l = 0; l < 1024; l++) tbmem[l] = pattern_line(10'(l));
      test_reset;
      test_read_miss;
      test_write_hit;
      test_lru_evict;
      test_dirty_writeback;
      test_reset_refill;
      test_ack_stall;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
